// File: rtl/fetch_bus_arbiter.sv
// Shares one memory read port between instruction fetch and LSU reads.
// One transaction in flight; LSU has priority, with a bound on fetch starvation.
module fetch_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] fetch_bus_addr,
  input  logic                  fetch_bus_read_req,
  input  logic                  fetch_flush,
  output logic [DATA_WIDTH-1:0] bus_fetch_data,
  output logic                  bus_fetch_read_ack,
  input  logic [ADDR_WIDTH-1:0] lsu_bus_addr,
  input  logic                  lsu_bus_read_req,
  output logic [DATA_WIDTH-1:0] bus_lsu_data,
  output logic                  bus_lsu_read_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  arb_busy
);

  // state  | meaning
  // S_IDLE | no transaction; arbitrate and capture one request
  // S_REQ  | mem_req driven, waiting for mem_gnt
  // S_WAIT | granted, waiting for mem_rvalid (response dropped if discard)
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic             owner_lsu;
  logic             discard;
  logic [CNT_W-1:0] starve_cnt;

  logic fetch_live;
  logic lsu_wins;
  logic fetch_wins;
  logic flush_own;
  logic drop_rsp;

  always_comb begin
    fetch_live = fetch_bus_read_req & ~fetch_flush;
    lsu_wins   = lsu_bus_read_req & ~(fetch_live & (starve_cnt == STARVE_MAX));
    fetch_wins = fetch_live & ~lsu_wins;
    flush_own  = fetch_flush & ~owner_lsu;
    // a flush landing together with rvalid still kills the fetch response
    drop_rsp   = discard | flush_own;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      owner_lsu          <= 1'b0;
      discard            <= 1'b0;
      starve_cnt         <= '0;
      mem_req            <= 1'b0;
      mem_addr           <= '0;
      arb_busy           <= 1'b0;
      bus_fetch_read_ack <= 1'b0;
      bus_lsu_read_ack   <= 1'b0;
      bus_fetch_data     <= '0;
      bus_lsu_data       <= '0;
    end else begin
      bus_fetch_read_ack <= 1'b0;
      bus_lsu_read_ack   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_wins) begin
            state     <= S_REQ;
            owner_lsu <= 1'b1;
            mem_addr  <= lsu_bus_addr;
            mem_req   <= 1'b1;
            arb_busy  <= 1'b1;
            if (fetch_bus_read_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (fetch_wins) begin
            state      <= S_REQ;
            owner_lsu  <= 1'b0;
            mem_addr   <= fetch_bus_addr;
            mem_req    <= 1'b1;
            arb_busy   <= 1'b1;
            starve_cnt <= '0;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
            if (flush_own) discard <= 1'b1;
          end else if (flush_own) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            arb_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state    <= S_IDLE;
            arb_busy <= 1'b0;
            discard  <= 1'b0;
            if (owner_lsu) begin
              bus_lsu_data     <= mem_rdata;
              bus_lsu_read_ack <= 1'b1;
            end else if (!drop_rsp) begin
              bus_fetch_data     <= mem_rdata;
              bus_fetch_read_ack <= 1'b1;
            end
          end else if (flush_own) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          mem_req  <= 1'b0;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// Directed bench for fetch_bus_arbiter: transaction-queue model checked every
// cycle, plus literal expectations per scenario.
module tb_fetch_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] fetch_bus_addr;
  logic          fetch_bus_read_req;
  logic          fetch_flush;
  logic [DW-1:0] bus_fetch_data;
  logic          bus_fetch_read_ack;
  logic [AW-1:0] lsu_bus_addr;
  logic          lsu_bus_read_req;
  logic [DW-1:0] bus_lsu_data;
  logic          bus_lsu_read_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_gnt;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          arb_busy;

  fetch_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .fetch_bus_addr(fetch_bus_addr), .fetch_bus_read_req(fetch_bus_read_req),
    .fetch_flush(fetch_flush), .bus_fetch_data(bus_fetch_data),
    .bus_fetch_read_ack(bus_fetch_read_ack),
    .lsu_bus_addr(lsu_bus_addr), .lsu_bus_read_req(lsu_bus_read_req),
    .bus_lsu_data(bus_lsu_data), .bus_lsu_read_ack(bus_lsu_read_ack),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .arb_busy(arb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 32'h8000_0000) return 64'h0000_006f_0000_0013;
    return {~a, a ^ 32'h5a5a_5a5a};
  endfunction

  // memory responder: grant after mem_req seen (unless blocked), rvalid after rv_delay
  bit            block_gnt = 0;
  int            rv_delay = 0;
  bit            rv_pend = 0;
  int            rv_cnt = 0;
  logic [AW-1:0] rv_addr = '0;
  logic [AW-1:0] gnt_addr = '0;

  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_gnt) begin
        rv_pend = 1;
        rv_cnt = rv_delay;
        rv_addr = gnt_addr;
      end
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = data_for(rv_addr);
          rv_pend = 0;
        end else begin
          rv_cnt--;
        end
      end
      mem_gnt = mem_req && !block_gnt;
      gnt_addr = mem_addr;
    end
  end

  // transaction-level model: at most one entry in the queue
  typedef struct {
    bit lsu;
    bit granted;
    bit dropped;
  } txn_t;

  txn_t          q[$];
  int            m_starve = 0;
  logic          e_mem_req = 0;
  logic [AW-1:0] e_mem_addr = '0;
  logic          e_fack = 0;
  logic          e_lack = 0;
  logic [DW-1:0] e_fdata = '0;
  logic [DW-1:0] e_ldata = '0;
  logic [AW-1:0] m_grants[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_starve = 0;
        e_mem_req = 0; e_mem_addr = '0;
        e_fack = 0; e_lack = 0; e_fdata = '0; e_ldata = '0;
      end else begin
        e_fack = 0;
        e_lack = 0;
        if (q.size() == 0) begin
          bit f_ok, l_win;
          txn_t t;
          f_ok = fetch_bus_read_req && !fetch_flush;
          l_win = lsu_bus_read_req && !(f_ok && m_starve == LIMIT);
          if (l_win || f_ok) begin
            t.lsu = l_win; t.granted = 0; t.dropped = 0;
            q.push_back(t);
            e_mem_req = 1;
            e_mem_addr = l_win ? lsu_bus_addr : fetch_bus_addr;
            m_grants.push_back(e_mem_addr);
            if (l_win && fetch_bus_read_req) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            if (!l_win) m_starve = 0;
          end
        end else if (!q[0].granted) begin
          if (mem_gnt) begin
            q[0].granted = 1;
            e_mem_req = 0;
            if (!q[0].lsu && fetch_flush) q[0].dropped = 1;
          end else if (!q[0].lsu && fetch_flush) begin
            q.delete();
            e_mem_req = 0;
          end
        end else begin
          if (mem_rvalid) begin
            if (q[0].lsu) begin
              e_lack = 1; e_ldata = mem_rdata;
            end else if (!(q[0].dropped || fetch_flush)) begin
              e_fack = 1; e_fdata = mem_rdata;
            end
            q.delete();
          end else if (!q[0].lsu && fetch_flush) begin
            q[0].dropped = 1;
          end
        end
      end
    end
  end

  // per-cycle compare, plus DUT-side grant log and ack counters
  logic [AW-1:0] dut_grants[$];
  int   dut_fack_cnt = 0;
  int   dut_lack_cnt = 0;
  logic prev_req = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("mem_req", 64'(mem_req), 64'(e_mem_req));
      check("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
      check("fetch_ack", 64'(bus_fetch_read_ack), 64'(e_fack));
      check("lsu_ack", 64'(bus_lsu_read_ack), 64'(e_lack));
      check("fetch_data", bus_fetch_data, e_fdata);
      check("lsu_data", bus_lsu_data, e_ldata);
      check("arb_busy", 64'(arb_busy), 64'(q.size() != 0));
      if (mem_req && !prev_req) dut_grants.push_back(mem_addr);
      prev_req = mem_req;
      if (bus_fetch_read_ack) dut_fack_cnt++;
      if (bus_lsu_read_ack) dut_lack_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    fetch_bus_read_req = 0;
    lsu_bus_read_req = 0;
    fetch_flush = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_ack(input bit lsu, input int max, output bit got);
    got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((lsu ? bus_lsu_read_ack : bus_fetch_read_ack) === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [AW-1:0] exp_pat[10];
  bit got;

  initial begin
    rst = 0;
    fetch_bus_addr = '0; fetch_bus_read_req = 0; fetch_flush = 0;
    lsu_bus_addr = '0; lsu_bus_read_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;

    // reset state
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_busy", 64'(arb_busy), 64'h0);
    check("rst_fetch_data", bus_fetch_data, 64'h0);
    check("rst_lsu_data", bus_lsu_data, 64'h0);

    // fetch only, minimum latency: ack exactly three edges after request
    dut_fack_cnt = 0; dut_lack_cnt = 0;
    @(negedge clk);
    fetch_bus_addr = 32'h8000_0000;
    fetch_bus_read_req = 1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      if (e == 1) begin
        check("fo_mem_req", 64'(mem_req), 64'h1);
        check("fo_mem_addr", 64'(mem_addr), 64'h8000_0000);
      end
      check("fo_ack_timing", 64'(bus_fetch_read_ack), 64'(e == 3));
      if (e == 3) begin
        check("fo_data", bus_fetch_data, 64'h0000_006f_0000_0013);
        fetch_bus_read_req = 0;
      end
    end
    check("fo_fack_once", 64'(dut_fack_cnt), 64'd1);
    check("fo_no_lsu_ack", 64'(dut_lack_cnt), 64'd0);

    // flush while in REQ with grant withheld
    block_gnt = 1;
    dut_fack_cnt = 0;
    @(negedge clk);
    fetch_bus_addr = 32'h8000_0080;
    fetch_bus_read_req = 1;
    @(negedge clk);
    check("fr_req_up", 64'(mem_req), 64'h1);
    @(negedge clk);
    fetch_flush = 1;
    @(negedge clk);
    check("fr_req_dropped", 64'(mem_req), 64'h0);
    check("fr_idle", 64'(arb_busy), 64'h0);
    fetch_flush = 0;
    fetch_bus_read_req = 0;
    block_gnt = 0;
    repeat (2) @(negedge clk);
    check("fr_no_ack", 64'(dut_fack_cnt), 64'd0);
    fetch_bus_addr = 32'h8000_0100;
    fetch_bus_read_req = 1;
    wait_ack(0, 20, got);
    fetch_bus_read_req = 0;
    check("fr_new_ack_seen", 64'(got), 64'h1);
    check("fr_new_data", bus_fetch_data, 64'h7fff_feff_da5a_5b5a);

    // flush while in WAIT, LSU pending behind it
    rv_delay = 2;
    dut_fack_cnt = 0;
    @(negedge clk);
    fetch_bus_addr = 32'h8000_0400;
    fetch_bus_read_req = 1;
    repeat (2) @(negedge clk);
    fetch_flush = 1;
    fetch_bus_read_req = 0;
    lsu_bus_addr = 32'h0000_2000;
    lsu_bus_read_req = 1;
    @(negedge clk);
    fetch_flush = 0;
    wait_ack(1, 20, got);
    lsu_bus_read_req = 0;
    check("fw_lsu_ack_seen", 64'(got), 64'h1);
    check("fw_lsu_data", bus_lsu_data, 64'hffff_dfff_5a5a_7a5a);
    check("fw_no_fetch_ack", 64'(dut_fack_cnt), 64'd0);
    check("fw_fetch_data_kept", bus_fetch_data, 64'h7fff_feff_da5a_5b5a);

    // flush with LSU owner must not cancel it
    rv_delay = 1;
    @(negedge clk);
    lsu_bus_addr = 32'h0000_3000;
    lsu_bus_read_req = 1;
    fetch_flush = 1;
    wait_ack(1, 20, got);
    lsu_bus_read_req = 0;
    fetch_flush = 0;
    check("fl_lsu_ack_seen", 64'(got), 64'h1);
    check("fl_lsu_data", bus_lsu_data, 64'hffff_cfff_5a5a_6a5a);

    // priority with starvation bound
    rv_delay = 0;
    do_reset();
    dut_grants.delete();
    m_grants.delete();
    lsu_bus_addr = 32'h0000_1000;
    fetch_bus_addr = 32'h8000_0200;
    lsu_bus_read_req = 1;
    fetch_bus_read_req = 1;
    for (int i = 0; i < 80 && dut_grants.size() < 10; i++) @(negedge clk);
    lsu_bus_read_req = 0;
    fetch_bus_read_req = 0;
    repeat (10) @(negedge clk);
    check("pr_grant_count", 64'(dut_grants.size() >= 10), 64'h1);
    foreach (exp_pat[i]) exp_pat[i] = (i % 5 == 4) ? 32'h8000_0200 : 32'h0000_1000;
    for (int i = 0; i < 10; i++) begin
      if (i < dut_grants.size()) check($sformatf("pr_dut_grant%0d", i), 64'(dut_grants[i]), 64'(exp_pat[i]));
      if (i < m_grants.size()) check($sformatf("pr_model_grant%0d", i), 64'(m_grants[i]), 64'(exp_pat[i]));
    end

    // async reset in WAIT, response arrives after release
    rv_delay = 3;
    dut_fack_cnt = 0; dut_lack_cnt = 0;
    @(negedge clk);
    fetch_bus_addr = 32'h8000_0300;
    fetch_bus_read_req = 1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("ar_busy_before", 64'(arb_busy), 64'h1);
    rst = 0;
    fetch_bus_read_req = 0;
    #1;
    check("ar_mem_req", 64'(mem_req), 64'h0);
    check("ar_mem_addr", 64'(mem_addr), 64'h0);
    check("ar_busy", 64'(arb_busy), 64'h0);
    check("ar_fetch_data", bus_fetch_data, 64'h0);
    check("ar_lsu_data", bus_lsu_data, 64'h0);
    check("ar_acks", 64'({bus_fetch_read_ack, bus_lsu_read_ack}), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
    check("ar_no_fetch_ack", 64'(dut_fack_cnt), 64'd0);
    check("ar_no_lsu_ack", 64'(dut_lack_cnt), 64'd0);
    check("ar_data_still_zero", bus_fetch_data, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
